// File: rtl/fan_drive_cntr.sv
// rtl/fan_drive_cntr.sv - fan speed/PWM controller with off-timer and echo (breeze) mode
module fan_drive_cntr #(
    parameter int SYS_CLK        = 100_000_000,
    parameter int PWM_FREQ       = 100,
    parameter int SPEED_LEVELS   = 4,
    parameter int DUTY_STEPS     = 6,
    parameter int TIMER_STEP_SEC = 5,
    parameter int TIMER_STEPS    = 3,
    parameter int ECHO_SEC       = 2,
    localparam int SW = $clog2(SPEED_LEVELS),
    localparam int TW = $clog2(TIMER_STEPS + 1),
    localparam int RW = $clog2(TIMER_STEPS * TIMER_STEP_SEC + 1)
) (
    input  logic          clk,
    input  logic          reset_p,
    input  logic          btn_power_pedge,
    input  logic          btn_timer_pedge,
    input  logic          btn_echo_pedge,
    output logic          pwm,
    output logic [SW-1:0] speed,
    output logic [SW-1:0] eff_level,
    output logic [TW-1:0] timer_sel,
    output logic [RW-1:0] remaining_sec,
    output logic          timer_active,
    output logic          echo_active,
    output logic          timer_expired
);

    localparam int SLOT      = SYS_CLK / (PWM_FREQ * DUTY_STEPS);
    localparam int DUTY_UNIT = DUTY_STEPS / (SPEED_LEVELS - 1);
    localparam int PW = (SYS_CLK > 1) ? $clog2(SYS_CLK) : 1;
    localparam int CW = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam int IW = (DUTY_STEPS > 1) ? $clog2(DUTY_STEPS) : 1;
    localparam int DW = $clog2(DUTY_STEPS + 1);
    localparam int EW = (ECHO_SEC > 1) ? $clog2(ECHO_SEC) : 1;

    logic [PW-1:0] sec_cnt_q, sec_cnt_d;
    logic [SW-1:0] speed_q, speed_d;
    logic [TW-1:0] sel_q, sel_d, sel_next;
    logic [RW-1:0] rem_q, rem_d;
    logic          active_q, active_d;
    logic          expired_q, expired_d;
    logic          echo_q, echo_d;
    logic          phase_q, phase_d;
    logic [EW-1:0] echo_cnt_q, echo_cnt_d;
    logic [CW-1:0] slot_cnt_q, slot_cnt_d;
    logic [IW-1:0] slot_idx_q, slot_idx_d;
    logic [DW-1:0] duty_q, duty_d;
    logic          pwm_q, pwm_d;
    logic          sec_tick, expire, slot_end, frame_end;
    logic [SW-1:0] eff;

    assign eff = (echo_q && phase_q) ? SW'(1) : speed_q;

    always_comb begin
        sec_cnt_d  = sec_cnt_q;
        speed_d    = speed_q;
        sel_d      = sel_q;
        rem_d      = rem_q;
        active_d   = active_q;
        expired_d  = 1'b0;
        echo_d     = echo_q;
        phase_d    = phase_q;
        echo_cnt_d = echo_cnt_q;

        sec_tick  = (sec_cnt_q == PW'(SYS_CLK - 1));
        sec_cnt_d = sec_tick ? '0 : sec_cnt_q + PW'(1);
        expire    = sec_tick && active_q && (rem_q == RW'(1));
        sel_next  = (sel_q == TW'(TIMER_STEPS)) ? '0 : sel_q + TW'(1);

        if (sec_tick && active_q && (rem_q > RW'(1)))
            rem_d = rem_q - RW'(1);

        // Expiry outranks power, power outranks timer; losers are dropped.
        if (expire) begin
            speed_d   = '0;
            expired_d = 1'b1;
        end else if (btn_power_pedge) begin
            speed_d = (speed_q == SW'(SPEED_LEVELS - 1)) ? '0 : speed_q + SW'(1);
        end else if (btn_timer_pedge && (speed_q != '0)) begin
            sel_d     = sel_next;
            rem_d     = RW'(32'(sel_next) * TIMER_STEP_SEC);
            active_d  = (sel_next != '0);
            sec_cnt_d = '0;
        end

        if (echo_q && sec_tick) begin
            if (echo_cnt_q == EW'(ECHO_SEC - 1)) begin
                echo_cnt_d = '0;
                phase_d    = ~phase_q;
            end else begin
                echo_cnt_d = echo_cnt_q + EW'(1);
            end
        end

        if (btn_echo_pedge && (speed_d != '0)) begin
            echo_d = ~echo_q;
            if (!echo_q) begin
                phase_d    = 1'b0;
                echo_cnt_d = '0;
            end
        end

        if (speed_d == '0) begin
            sel_d    = '0;
            rem_d    = '0;
            active_d = 1'b0;
            echo_d   = 1'b0;
        end
    end

    // Duty is sampled only on the last cycle of a frame so frames are never cut short.
    always_comb begin
        slot_end   = (slot_cnt_q == CW'(SLOT - 1));
        frame_end  = slot_end && (slot_idx_q == IW'(DUTY_STEPS - 1));
        slot_cnt_d = slot_end ? '0 : slot_cnt_q + CW'(1);
        slot_idx_d = slot_idx_q;
        if (slot_end)
            slot_idx_d = frame_end ? '0 : slot_idx_q + IW'(1);
        duty_d = frame_end ? DW'(32'(eff) * DUTY_UNIT) : duty_q;
        pwm_d  = (32'(slot_idx_d) < 32'(duty_d));
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            sec_cnt_q  <= '0;
            speed_q    <= '0;
            sel_q      <= '0;
            rem_q      <= '0;
            active_q   <= 1'b0;
            expired_q  <= 1'b0;
            echo_q     <= 1'b0;
            phase_q    <= 1'b0;
            echo_cnt_q <= '0;
            slot_cnt_q <= '0;
            slot_idx_q <= '0;
            duty_q     <= '0;
            pwm_q      <= 1'b0;
        end else begin
            sec_cnt_q  <= sec_cnt_d;
            speed_q    <= speed_d;
            sel_q      <= sel_d;
            rem_q      <= rem_d;
            active_q   <= active_d;
            expired_q  <= expired_d;
            echo_q     <= echo_d;
            phase_q    <= phase_d;
            echo_cnt_q <= echo_cnt_d;
            slot_cnt_q <= slot_cnt_d;
            slot_idx_q <= slot_idx_d;
            duty_q     <= duty_d;
            pwm_q      <= pwm_d;
        end
    end

    assign pwm           = pwm_q;
    assign speed         = speed_q;
    assign eff_level     = eff;
    assign timer_sel     = sel_q;
    assign remaining_sec = rem_q;
    assign timer_active  = active_q;
    assign echo_active   = echo_q;
    assign timer_expired = expired_q;

endmodule

// File: tb/tb_fan_drive_cntr.sv
// tb/tb_fan_drive_cntr.sv - directed self-checking bench for fan_drive_cntr
module tb_fan_drive_cntr;

    logic       clk = 1'b0;
    logic       reset_p = 1'b1;
    logic       btn_power_pedge = 1'b0;
    logic       btn_timer_pedge = 1'b0;
    logic       btn_echo_pedge = 1'b0;
    logic       pwm;
    logic [1:0] speed;
    logic [1:0] eff_level;
    logic [1:0] timer_sel;
    logic [3:0] remaining_sec;
    logic       timer_active;
    logic       echo_active;
    logic       timer_expired;

    int errors = 0;
    int checks = 0;

    fan_drive_cntr #(
        .SYS_CLK(600), .PWM_FREQ(10), .SPEED_LEVELS(4), .DUTY_STEPS(6),
        .TIMER_STEP_SEC(5), .TIMER_STEPS(3), .ECHO_SEC(2)
    ) dut (
        .clk(clk), .reset_p(reset_p),
        .btn_power_pedge(btn_power_pedge), .btn_timer_pedge(btn_timer_pedge),
        .btn_echo_pedge(btn_echo_pedge),
        .pwm(pwm), .speed(speed), .eff_level(eff_level), .timer_sel(timer_sel),
        .remaining_sec(remaining_sec), .timer_active(timer_active),
        .echo_active(echo_active), .timer_expired(timer_expired)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_power();
        btn_power_pedge = 1'b1; tick(); btn_power_pedge = 1'b0;
    endtask

    task automatic pulse_timer();
        btn_timer_pedge = 1'b1; tick(); btn_timer_pedge = 1'b0;
    endtask

    task automatic pulse_echo();
        btn_echo_pedge = 1'b1; tick(); btn_echo_pedge = 1'b0;
    endtask

    task automatic count_pwm(input int n, output int h);
        h = 0;
        for (int i = 0; i < n; i++) begin
            if (pwm === 1'b1) h++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset_p = 1'b1; tick(); tick(); reset_p = 1'b0;
        checks++;
        if ({pwm, speed, eff_level, timer_sel, remaining_sec, timer_active, echo_active, timer_expired} !== 15'd0) begin
            errors++;
            $display("FAIL reset_state: got pwm=%b speed=%0d eff=%0d sel=%0d rem=%0d ta=%b ea=%b te=%b, need all 0",
                     pwm, speed, eff_level, timer_sel, remaining_sec, timer_active, echo_active, timer_expired);
        end
    endtask

    task automatic test_power_levels();
        int h;
        int exp_hi [4] = '{20, 40, 60, 0};
        for (int n = 1; n <= 4; n++) begin
            pulse_power();
            checks++;
            if (speed !== 2'(n % 4)) begin
                errors++;
                $display("FAIL power_speed_%0d: got %0d, need %0d", n, speed, n % 4);
            end
            repeat (120) tick();
            count_pwm(60, h);
            checks++;
            if (h != exp_hi[n-1]) begin
                errors++;
                $display("FAIL power_pwm_%0d: got %0d high cycles, need %0d", n, h, exp_hi[n-1]);
            end
        end
    endtask

    task automatic test_timer_expiry();
        int cnt;
        int h;
        pulse_power();
        pulse_timer();
        checks++;
        if (remaining_sec !== 4'd5 || timer_active !== 1'b1 || timer_sel !== 2'd1) begin
            errors++;
            $display("FAIL timer_load: got rem=%0d ta=%b sel=%0d, need 5 1 1", remaining_sec, timer_active, timer_sel);
        end
        cnt = 0;
        while (timer_expired !== 1'b1 && cnt < 4000) begin
            tick();
            cnt++;
        end
        checks++;
        if (cnt != 3000) begin
            errors++;
            $display("FAIL expiry_latency: got %0d cycles, need 3000", cnt);
        end
        checks++;
        if (speed !== 2'd0 || timer_active !== 1'b0 || remaining_sec !== 4'd0 || timer_sel !== 2'd0) begin
            errors++;
            $display("FAIL expiry_state: got speed=%0d ta=%b rem=%0d sel=%0d, need 0 0 0 0",
                     speed, timer_active, remaining_sec, timer_sel);
        end
        tick();
        checks++;
        if (timer_expired !== 1'b0) begin
            errors++;
            $display("FAIL expiry_one_cycle: got %b, need 0", timer_expired);
        end
        repeat (60) tick();
        count_pwm(60, h);
        checks++;
        if (h != 0) begin
            errors++;
            $display("FAIL expiry_pwm_off: got %0d high cycles, need 0", h);
        end
    endtask

    task automatic test_timer_steps();
        logic [3:0] exp_rem [4] = '{4'd5, 4'd10, 4'd15, 4'd0};
        pulse_power();
        pulse_power();
        for (int i = 0; i < 4; i++) begin
            pulse_timer();
            checks++;
            if (remaining_sec !== exp_rem[i] || timer_sel !== 2'((i + 1) % 4)) begin
                errors++;
                $display("FAIL timer_step_%0d: got rem=%0d sel=%0d, need %0d %0d",
                         i, remaining_sec, timer_sel, exp_rem[i], (i + 1) % 4);
            end
        end
        checks++;
        if (timer_active !== 1'b0) begin
            errors++;
            $display("FAIL timer_wrap_active: got %b, need 0", timer_active);
        end
        pulse_power();
        pulse_power();
        pulse_timer();
        checks++;
        if (speed !== 2'd0 || timer_sel !== 2'd0 || remaining_sec !== 4'd0 || timer_active !== 1'b0) begin
            errors++;
            $display("FAIL timer_at_off: got speed=%0d sel=%0d rem=%0d ta=%b, need 0 0 0 0",
                     speed, timer_sel, remaining_sec, timer_active);
        end
    endtask

    task automatic test_priority();
        pulse_power();
        pulse_timer();
        repeat (2999) tick();
        pulse_power();
        checks++;
        if (speed !== 2'd0 || timer_expired !== 1'b1) begin
            errors++;
            $display("FAIL expiry_beats_power: got speed=%0d te=%b, need 0 1", speed, timer_expired);
        end
        pulse_power();
        pulse_timer();
        btn_power_pedge = 1'b1;
        btn_timer_pedge = 1'b1;
        tick();
        btn_power_pedge = 1'b0;
        btn_timer_pedge = 1'b0;
        checks++;
        if (speed !== 2'd2 || timer_sel !== 2'd1 || remaining_sec !== 4'd5) begin
            errors++;
            $display("FAIL power_beats_timer: got speed=%0d sel=%0d rem=%0d, need 2 1 5",
                     speed, timer_sel, remaining_sec);
        end
        pulse_power();
        pulse_power();
    endtask

    task automatic test_echo();
        int t;
        int h;
        pulse_power();
        pulse_power();
        pulse_power();
        pulse_echo();
        checks++;
        if (echo_active !== 1'b1 || eff_level !== 2'd3) begin
            errors++;
            $display("FAIL echo_enter: got ea=%b eff=%0d, need 1 3", echo_active, eff_level);
        end
        t = 0;
        while (eff_level !== 2'd1 && t < 2500) begin
            tick();
            t++;
        end
        checks++;
        if (t > 1200 || t == 0) begin
            errors++;
            $display("FAIL echo_first_toggle: got %0d cycles, need 1..1200", t);
        end
        for (int p = 0; p < 2; p++) begin
            t = 0;
            repeat (120) tick();
            count_pwm(60, h);
            t = 180;
            checks++;
            if (h != (p == 0 ? 20 : 60)) begin
                errors++;
                $display("FAIL echo_pwm_phase%0d: got %0d high cycles, need %0d", p, h, p == 0 ? 20 : 60);
            end
            while (eff_level !== (p == 0 ? 2'd3 : 2'd1) && t < 3000) begin
                tick();
                t++;
            end
            checks++;
            if (t != 1200) begin
                errors++;
                $display("FAIL echo_period_%0d: got %0d cycles, need 1200", p, t);
            end
        end
        pulse_power();
        checks++;
        if (speed !== 2'd0 || echo_active !== 1'b0 || eff_level !== 2'd0) begin
            errors++;
            $display("FAIL echo_off_at_zero: got speed=%0d ea=%b eff=%0d, need 0 0 0", speed, echo_active, eff_level);
        end
    endtask

    task automatic test_reset_midcount();
        int seen;
        pulse_power();
        pulse_timer();
        repeat (1500) tick();
        checks++;
        if (remaining_sec !== 4'd3) begin
            errors++;
            $display("FAIL pre_reset_rem: got %0d, need 3", remaining_sec);
        end
        reset_p = 1'b1; tick(); reset_p = 1'b0;
        checks++;
        if ({pwm, speed, eff_level, timer_sel, remaining_sec, timer_active, echo_active, timer_expired} !== 15'd0) begin
            errors++;
            $display("FAIL midcount_reset: got pwm=%b speed=%0d sel=%0d rem=%0d ta=%b te=%b, need all 0",
                     pwm, speed, timer_sel, remaining_sec, timer_active, timer_expired);
        end
        seen = 0;
        for (int i = 0; i < 3000; i++) begin
            if (timer_expired === 1'b1) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL no_expiry_after_reset: got %0d pulses, need 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_power_levels();
        test_timer_expiry();
        test_timer_steps();
        test_priority();
        test_echo();
        test_reset_midcount();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fan_drive_cntr.md
FAN_DRIVE_CNTR -- requirements
Module: fan_drive_cntr

Interface
REQ-001 Parameter SYS_CLK, default 100_000_000: clock frequency in Hz; one second = SYS_CLK cycles.
REQ-002 Parameter PWM_FREQ, default 100: PWM frame rate in Hz.
REQ-003 Parameter SPEED_LEVELS, default 4: number of speed states, where 0 is off; SHALL be at least 2.
REQ-004 Parameter DUTY_STEPS, default 6: PWM slots per frame; SHALL be a multiple of SPEED_LEVELS-1.
REQ-005 Parameter TIMER_STEP_SEC, default 5: seconds added per timer selection step.
REQ-006 Parameter TIMER_STEPS, default 3: maximum timer selection; selections are 0..TIMER_STEPS.
REQ-007 Parameter ECHO_SEC, default 2: echo-mode alternation half-period in seconds.
REQ-008 Derived widths: SW = clog2(SPEED_LEVELS); TW = clog2(TIMER_STEPS+1); RW = clog2(TIMER_STEPS*TIMER_STEP_SEC+1).
REQ-009 Port clk, input, 1: single system clock; all logic on posedge.
REQ-010 Port reset_p, input, 1: synchronous, active-high reset.
REQ-011 Port btn_power_pedge, input, 1: one-cycle pulse that advances the speed.
REQ-012 Port btn_timer_pedge, input, 1: one-cycle pulse that advances the off-timer selection.
REQ-013 Port btn_echo_pedge, input, 1: one-cycle pulse that toggles echo mode.
REQ-014 Port pwm, output, 1: motor drive.
REQ-015 Port speed, output, SW: selected speed 0..SPEED_LEVELS-1.
REQ-016 Port eff_level, output, SW: level currently driving the PWM.
REQ-017 Port timer_sel, output, TW: current timer selection.
REQ-018 Port remaining_sec, output, RW: countdown value in seconds.
REQ-019 Port timer_active, echo_active, output, 1 each: mode flags.
REQ-020 Port timer_expired, output, 1: one-cycle pulse when the countdown ends.

Function
REQ-021 Each power pulse SHALL set speed to speed+1, wrapping from SPEED_LEVELS-1 to 0, with the new value visible the next cycle.
REQ-022 Whenever speed becomes 0, the block SHALL in the same update clear timer_sel, remaining_sec, timer_active and echo_active.
REQ-023 A timer pulse received while speed==0 SHALL be ignored.
REQ-024 Otherwise a timer pulse SHALL:
- set timer_sel to (timer_sel+1) mod (TIMER_STEPS+1);
- load remaining_sec with new_sel*TIMER_STEP_SEC;
- set timer_active to (new_sel!=0);
- restart the one-second prescaler at 0.
REQ-025 A free-running one-second prescaler SHALL count 0..SYS_CLK-1 and emit sec_tick on its terminal count.
REQ-026 On sec_tick with timer_active and remaining_sec>1, remaining_sec SHALL decrement by 1.
REQ-027 On sec_tick with timer_active and remaining_sec==1, the next cycle SHALL show:
- remaining_sec=0 and timer_active=0;
- timer_sel=0;
- speed=0 and echo_active=0;
- timer_expired=1 for exactly one cycle.
REQ-028 Simultaneous-event priority SHALL be:
- expiry beats the power pulse, so the power pulse is dropped;
- the power pulse beats the timer pulse, so the timer pulse is dropped;
- an echo pulse is always evaluated against the post-update speed.
REQ-029 An echo pulse SHALL toggle echo_active when speed!=0 and be ignored when speed==0; entering echo SHALL clear the echo phase and echo second counter.
REQ-030 eff_level SHALL equal speed when echo_active==0.
REQ-031 When echo_active==1, eff_level SHALL alternate between speed (phase 0) and 1 (phase 1), toggling phase every ECHO_SEC sec_ticks.
REQ-032 The PWM frame SHALL consist of DUTY_STEPS slots, each SLOT = SYS_CLK/(PWM_FREQ*DUTY_STEPS) cycles (integer truncation).
REQ-033 The slot index SHALL wrap from DUTY_STEPS-1 to 0.
REQ-034 The duty in slots SHALL be eff_level*(DUTY_STEPS/(SPEED_LEVELS-1)).
REQ-035 pwm SHALL be 1 while slot index < duty; the output SHALL be registered and free of glitches.
REQ-036 A duty change SHALL take effect only at a frame boundary (slot index 0, start of slot), so no frame is ever truncated.
REQ-037 With eff_level==0, pwm SHALL be constant 0; with eff_level==SPEED_LEVELS-1, pwm SHALL be constant 1.

Reset
REQ-038 While reset_p is high at a posedge, all registers SHALL clear, giving the following outputs the next cycle:
- pwm=0, speed=0, eff_level=0;
- timer_sel=0, remaining_sec=0;
- timer_active=0, echo_active=0, timer_expired=0.
REQ-039 Reset asserted mid-countdown or mid-frame SHALL abort the operation; no timer_expired pulse SHALL be produced.

Verification
Bench parameters: SYS_CLK=600, PWM_FREQ=10, SPEED_LEVELS=4, DUTY_STEPS=6, TIMER_STEP_SEC=5, TIMER_STEPS=3, ECHO_SEC=2. This gives SLOT=10 cycles, a 60-cycle frame, and 600 cycles per second.
REQ-040 Power pulses x1, x2, x3, x4 -> speed 1, 2, 3, 0; pwm high 20, 40, 60 and 0 cycles per 60-cycle frame respectively.
REQ-041 Speed 1, then timer pulse -> remaining_sec=5 and timer_active=1; after 3000 cycles -> timer_expired pulses once, speed=0, pwm low from the next frame.
REQ-042 Timer pulses x4 at speed 2 -> remaining_sec 5, 10, 15, 0; timer_active ends at 0; a timer pulse at speed 0 -> no change.
REQ-043 Power pulse on the same cycle as the expiry tick -> speed=0 and the power pulse is dropped; power and timer pulses together -> speed advances and timer_sel is unchanged.
REQ-044 Speed 3 with echo on -> eff_level alternates 3 and 1 every 1200 cycles (pwm 60 then 20 high per frame); a power pulse wraps speed to 0 -> echo_active=0.
REQ-045 Reset pulse at remaining_sec=3 -> all outputs equal their reset values the next cycle and no timer_expired pulse occurs.
